// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter width for N/W steps, never narrower than one bit.
    function automatic int cnt_width(input int n, input int w);
        int steps;
        steps = n / w;
        if (steps <= 1) begin
            return 1;
        end else begin
            return $clog2(steps);
        end
    endfunction

    // One-bit full subtractor: returns {borrow_out, difference}.
    function automatic logic [1:0] fs_bit(input logic a, input logic b, input logic br);
        logic d;
        logic br_next;
        d       = a ^ b ^ br;
        br_next = (~a & b) | (~(a ^ b) & br);
        return {br_next, d};
    endfunction

endpackage

// File: rtl/serial_subtractor_slice.sv
// W-bit combinational ripple-borrow subtractor slice used by serial_subtractor.
module full_subtractor_slice
    import serial_subtractor_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] w_br;

    assign w_br[0] = bin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic [1:0] w_res;
        assign w_res      = fs_bit(a[i], b[i], w_br[i]);
        assign d[i]       = w_res[0];
        assign w_br[i+1]  = w_res[1];
    end

    assign bout = w_br[W];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle N-bit subtractor, W bits per cycle, valid/ready on both sides.
// Define SERIAL_SUBTRACTOR_OVERFLOW_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic         ovf
`endif
);

    localparam int              CW    = cnt_width(N, W);
    localparam int              STEPS = N / W;
    localparam logic [CW-1:0]   LAST  = CW'(STEPS - 1);

    if (N < 2 || W < 1 || (N % W) != 0) begin : g_param_check
        $error("serial_subtractor: N must be >= 2 and divisible by W");
    end

    state_t         r_state;
    state_t         w_state_next;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_diff;
    logic           r_borrow;
    logic [CW-1:0]  r_cnt;

    logic           w_accept;
    logic           w_last;
    logic [W-1:0]   w_d;
    logic           w_bout;
    logic [N+W-1:0] w_diff_cat;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic           r_a_msb;
    logic           r_b_msb;
    logic           r_ovf;
`endif

    full_subtractor_slice #(.W(W)) u_slice (
        .a    (r_a[W-1:0]),
        .b    (r_b[W-1:0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_accept   = in_valid & r_in_ready;
    assign w_last     = (r_cnt == LAST);
    // Slice result enters at the top of diff; the window below keeps the upper N bits.
    assign w_diff_cat = {w_d, r_diff};

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RUN;
                end
            end
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, handshake flags and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == IDLE);
            // Valid follows one cycle into DONE so the result is settled first.
            r_out_valid <= (r_state == DONE) && (w_state_next == DONE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_diff   <= '0;
                        r_cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                        r_a_msb  <= a[N-1];
                        r_b_msb  <= b[N-1];
                        r_ovf    <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    r_a      <= r_a >> W;
                    r_b      <= r_b >> W;
                    r_diff   <= w_diff_cat[N+W-1:W];
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CW'(1);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    if (w_last) begin
                        r_ovf <= (r_a_msb != r_b_msb) && (w_d[W-1] != r_a_msb);
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_borrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    assign ovf       = r_ovf;
`endif

endmodule
